park_exit_ctrl: RTL and testbench
=================================

Name: park_exit_ctrl

Overview:
- Exit-side controller for the car park: owns the slot occupancy table.
- Accepts vehicle registrations from the entry gate and authenticated exit requests.
- For an exit request it checks the password, scans the table for the vehicle number, frees the slot and opens the exit gate for a fixed time.
- Sits beside the entry gate controller; the entry side drives `ent_valid` / `ent_vn`.

Parameters:
- N, 4, width of vehicle number and password.
- SLOTS, 16, number of parking slots (power of 2, ≤ 2^N).
- PASSWORD, 4'b1010, exit password, N bits.
- GATE_CYCLES, 4, clock cycles the exit gate stays open (≥ 1).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- ent_valid  in  1  entry registration request (1-cycle pulse).
- ent_vn  in  N  vehicle number to store.
- ent_ack  out  1  1-cycle pulse: registration stored.
- ent_slot  out  log2(SLOTS)  slot index assigned; valid with ent_ack.
- full  out  1  all slots occupied.
- occ_count  out  log2(SLOTS)+1  number of occupied slots.
- exit_req  in  1  exit request; sampled only when busy=0.
- exit_pswd  in  N  password presented with exit_req.
- exit_vn  in  N  vehicle number presented with exit_req.
- busy  out  1  exit FSM not in IDLE.
- exit_gate  out  1  exit gate open.
- exit_slot  out  log2(SLOTS)  slot freed; valid from exit_gate rise until next request.
- exit_done  out  1  1-cycle pulse: exit transaction finished.
- exit_err  out  2  valid with exit_done: 00 ok, 01 bad password, 10 vehicle not found.

Behaviour:
- Reset (rst=1 at an edge) clears all table valid bits.
- Reset zeroes every output, including exit_slot.
- Reset forces the FSM to IDLE; it aborts a scan or open gate mid-operation, so the gate closes on the next edge.
- Entry path (independent of exit FSM):
  - ent_valid=1 with full=0 writes ent_vn into the lowest-index free slot and sets its valid bit.
  - ent_ack=1 and ent_slot=index appear the next cycle.
  - ent_valid with full=1 is dropped: no ack, table unchanged.
- Exit FSM states: IDLE, CHECK, SEARCH, OPEN, DENY.
  - IDLE: exit_req=1 latches exit_pswd/exit_vn → CHECK.
  - CHECK: pswd==PASSWORD → SEARCH with idx=0; else → DENY with err=01.
  - SEARCH: compares slot idx, one slot per cycle.
    - valid && vn match → clear valid bit, exit_slot=idx, → OPEN.
    - Else, if idx==SLOTS-1 → DENY with err=10; otherwise idx+1.
  - OPEN: exit_gate=1 for exactly GATE_CYCLES cycles. On the last cycle, exit_done pulses with err=00 → IDLE.
  - DENY: exit_done=1 with exit_err for 1 cycle; exit_gate stays 0 → IDLE.
- Latency, for a match at slot k: exit_gate rises after the (k+2)th rising edge following the edge that sampled exit_req.
- Worst-case not-found latency: exit_done at edge SLOTS+2.
- exit_req while busy=1 is ignored; it is not queued.
- Duplicate vehicle numbers: the lowest-index match is freed; others remain.
- Simultaneous entry write and exit free in the same cycle:
  - The slot being freed is not eligible for that entry.
  - occ_count nets to unchanged.
  - An entry write to the slot currently under SEARCH is visible the next compare cycle only.
- occ_count and full are registered and consistent with the table every cycle.

Optional Feature:
- Macro: PARK_EXIT_FEE_EN.
- Defined:
  - Adds input tick (1 bit) and output fee (8 bits).
  - Each slot has an 8-bit saturating duration counter, cleared on entry write and incremented on tick while occupied.
  - On a SEARCH match, fee latches that slot's counter and is valid with exit_done (err=00).
  - fee resets to 0.
- Undefined: no tick/fee ports and no counters; all other behaviour identical.

Decomposition:
- Package park_pkg holds:
  - the exit FSM state enum;
  - error-code constants ERR_OK/ERR_PSWD/ERR_NOTFOUND;
  - the default PASSWORD and GATE_CYCLES constants.
- Sub-module park_slot_table holds:
  - vn storage and valid bits;
  - the lowest-free priority encoder;
  - occ_count/full;
  - optional fee counters.
- Its ports are one write port, one read/compare index and one clear strobe.
- park_exit_ctrl holds the FSM and gate timer.

Test Plan:
- Reset, then 3 entries vn=5,9,3 → ent_slot 0,1,2; occ_count=3. Exit pswd=1010 vn=9 → gate high 4 cycles at edge 3, exit_slot=1, done err=00, occ_count=2.
- Exit pswd=0110 vn=5 → no gate, exit_done at edge 2 with err=01, table unchanged.
- Exit pswd=1010 vn=7 (absent) → exit_done at edge 18, err=10, gate never 1.
- Fill 16 slots → full=1. Extra ent_valid → no ack. Exit vn in slot 4, then entry in the same cycle as the free → entry gets no slot that cycle; next entry gets slot 4.
- Assert rst during OPEN → exit_gate=0, busy=0 and occ_count=0 after that edge. exit_req while busy → ignored.
- With PARK_EXIT_FEE_EN defined: enter vn=2, 300 ticks, exit → fee=255 (saturated). Enter, 10 ticks, exit → fee=10.

Source files
------------

// File: rtl/park_pkg.sv
// Shared types and constants for the car park exit controller and its slot table.
// Optional fee counters are enabled by defining PARK_EXIT_FEE_EN.
package park_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_SEARCH = 3'd2,
    ST_OPEN   = 3'd3,
    ST_DENY   = 3'd4
  } exit_state_e;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_PSWD     = 2'b01;
  localparam logic [1:0] ERR_NOTFOUND = 2'b10;

  localparam logic [3:0] DEF_PASSWORD    = 4'b1010;
  localparam int         DEF_GATE_CYCLES = 4;
  localparam int         FEE_W           = 8;

endpackage

// File: rtl/park_slot_table.sv
// Slot occupancy table: vehicle numbers, valid bits, lowest-free allocation and occupancy count.
// With PARK_EXIT_FEE_EN defined, each slot also keeps a saturating duration counter.
module park_slot_table
  import park_pkg::*;
#(
  parameter int N     = 4,
  parameter int SLOTS = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [N-1:0]               wr_vn,
  output logic                       wr_ack,
  output logic [$clog2(SLOTS)-1:0]   wr_slot,
  output logic                       full,
  output logic [$clog2(SLOTS):0]     occ_count,
  input  logic [$clog2(SLOTS)-1:0]   rd_idx,
  output logic                       rd_valid,
  output logic [N-1:0]               rd_vn,
`ifdef PARK_EXIT_FEE_EN
  input  logic                       tick,
  output logic [FEE_W-1:0]           rd_fee,
`endif
  input  logic                       clr_en
);

  localparam int IW = $clog2(SLOTS);

  logic [SLOTS-1:0] valid_q, valid_d;
  logic [N-1:0]     vn_q [SLOTS];
  logic [N-1:0]     vn_d [SLOTS];
  logic             wr_ack_q, wr_ack_d;
  logic [IW-1:0]    wr_slot_q, wr_slot_d;
  logic [IW:0]      cnt_q, cnt_d;
  logic             full_q, full_d;
  logic [IW-1:0]    free_idx;
  logic             wr_fire;

  // Allocation looks only at the registered valid bits, so a slot being
  // cleared this cycle cannot be handed to a simultaneous entry.
  always_comb begin
    free_idx = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = IW'(i);
    end
  end

  assign wr_fire = wr_en && !full_q;

  always_comb begin
    valid_d   = valid_q;
    vn_d      = vn_q;
    wr_ack_d  = wr_fire;
    wr_slot_d = wr_slot_q;
    if (clr_en) valid_d[rd_idx] = 1'b0;
    if (wr_fire) begin
      valid_d[free_idx] = 1'b1;
      vn_d[free_idx]    = wr_vn;
      wr_slot_d         = free_idx;
    end
    cnt_d  = cnt_q + (IW+1)'(wr_fire) - (IW+1)'(clr_en);
    full_d = (cnt_d == (IW+1)'(SLOTS));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= '0;
      wr_ack_q  <= 1'b0;
      wr_slot_q <= '0;
      cnt_q     <= '0;
      full_q    <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      wr_ack_q  <= wr_ack_d;
      wr_slot_q <= wr_slot_d;
      cnt_q     <= cnt_d;
      full_q    <= full_d;
    end
    vn_q <= vn_d;
  end

`ifdef PARK_EXIT_FEE_EN
  logic [FEE_W-1:0] dur_q [SLOTS];
  logic [FEE_W-1:0] dur_d [SLOTS];

  always_comb begin
    for (int i = 0; i < SLOTS; i++) begin
      dur_d[i] = dur_q[i];
      if (wr_fire && (free_idx == IW'(i))) begin
        dur_d[i] = '0;
      end else if (tick && valid_q[i] && (dur_q[i] != '1)) begin
        dur_d[i] = dur_q[i] + FEE_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < SLOTS; i++) begin
      if (rst) dur_q[i] <= '0;
      else     dur_q[i] <= dur_d[i];
    end
  end

  assign rd_fee = dur_q[rd_idx];
`endif

  assign wr_ack    = wr_ack_q;
  assign wr_slot   = wr_slot_q;
  assign full      = full_q;
  assign occ_count = cnt_q;
  assign rd_valid  = valid_q[rd_idx];
  assign rd_vn     = vn_q[rd_idx];

endmodule

// File: rtl/park_exit_ctrl.sv
// Car park exit controller: password check, linear slot search, timed exit gate.
// Define PARK_EXIT_FEE_EN to add the tick input and the fee output.
module park_exit_ctrl
  import park_pkg::*;
#(
  parameter int           N           = 4,
  parameter int           SLOTS       = 16,
  parameter logic [N-1:0] PASSWORD    = N'(DEF_PASSWORD),
  parameter int           GATE_CYCLES = DEF_GATE_CYCLES
) (
  input  logic                     clk,
  input  logic                     rst,
`ifdef PARK_EXIT_FEE_EN
  input  logic                     tick,
  output logic [7:0]               fee,
`endif
  input  logic                     ent_valid,
  input  logic [N-1:0]             ent_vn,
  output logic                     ent_ack,
  output logic [$clog2(SLOTS)-1:0] ent_slot,
  output logic                     full,
  output logic [$clog2(SLOTS):0]   occ_count,
  input  logic                     exit_req,
  input  logic [N-1:0]             exit_pswd,
  input  logic [N-1:0]             exit_vn,
  output logic                     busy,
  output logic                     exit_gate,
  output logic [$clog2(SLOTS)-1:0] exit_slot,
  output logic                     exit_done,
  output logic [1:0]               exit_err
);

  localparam int IW = $clog2(SLOTS);
  localparam int TW = $clog2(GATE_CYCLES + 1);

  exit_state_e   state_q, state_d;
  logic [N-1:0]  pswd_q, pswd_d;
  logic [N-1:0]  vn_q, vn_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] slot_q, slot_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          gate_q, gate_d;
  logic          done_q, done_d;
  logic [1:0]    err_q, err_d;
  logic          rd_valid;
  logic [N-1:0]  rd_vn;
  logic          hit;
`ifdef PARK_EXIT_FEE_EN
  logic [FEE_W-1:0] rd_fee;
  logic [FEE_W-1:0] fee_q, fee_d;
`endif

  park_slot_table #(.N(N), .SLOTS(SLOTS)) u_table (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (ent_valid),
    .wr_vn     (ent_vn),
    .wr_ack    (ent_ack),
    .wr_slot   (ent_slot),
    .full      (full),
    .occ_count (occ_count),
    .rd_idx    (idx_q),
    .rd_valid  (rd_valid),
    .rd_vn     (rd_vn),
`ifdef PARK_EXIT_FEE_EN
    .tick      (tick),
    .rd_fee    (rd_fee),
`endif
    .clr_en    (hit)
  );

  // The match also serves as the table's clear strobe for the slot under search.
  assign hit = (state_q == ST_SEARCH) && rd_valid && (rd_vn == vn_q);

  always_comb begin
    state_d = state_q;
    pswd_d  = pswd_q;
    vn_d    = vn_q;
    idx_d   = idx_q;
    slot_d  = slot_q;
    timer_d = timer_q;
    gate_d  = gate_q;
    done_d  = 1'b0;
    err_d   = err_q;
`ifdef PARK_EXIT_FEE_EN
    fee_d   = fee_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (exit_req) begin
          pswd_d  = exit_pswd;
          vn_d    = exit_vn;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (pswd_q == PASSWORD) begin
          idx_d   = '0;
          state_d = ST_SEARCH;
        end else begin
          err_d   = ERR_PSWD;
          state_d = ST_DENY;
        end
      end
      ST_SEARCH: begin
        if (hit) begin
          slot_d  = idx_q;
          gate_d  = 1'b1;
          timer_d = TW'(GATE_CYCLES - 1);
          done_d  = (GATE_CYCLES == 1);
          err_d   = ERR_OK;
          state_d = ST_OPEN;
`ifdef PARK_EXIT_FEE_EN
          fee_d   = rd_fee;
`endif
        end else if (idx_q == IW'(SLOTS - 1)) begin
          err_d   = ERR_NOTFOUND;
          state_d = ST_DENY;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      ST_OPEN: begin
        // exit_done lands on the last gate-high cycle, not after it.
        if (timer_q == '0) begin
          gate_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q - TW'(1);
          done_d  = (timer_q == TW'(1));
        end
      end
      ST_DENY: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pswd_q  <= '0;
      vn_q    <= '0;
      idx_q   <= '0;
      slot_q  <= '0;
      timer_q <= '0;
      gate_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= ERR_OK;
`ifdef PARK_EXIT_FEE_EN
      fee_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      pswd_q  <= pswd_d;
      vn_q    <= vn_d;
      idx_q   <= idx_d;
      slot_q  <= slot_d;
      timer_q <= timer_d;
      gate_q  <= gate_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef PARK_EXIT_FEE_EN
      fee_q   <= fee_d;
`endif
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign exit_gate = gate_q;
  assign exit_slot = slot_q;
  assign exit_done = done_q;
  assign exit_err  = err_q;
`ifdef PARK_EXIT_FEE_EN
  assign fee       = fee_q;
`endif

endmodule

// File: tb/tb_park_exit_ctrl.sv
// Self-checking bench for park_exit_ctrl: transaction-level model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_park_exit_ctrl;

  localparam int           N     = 4;
  localparam int           SLOTS = 16;
  localparam int           IW    = 4;
  localparam int           G     = 4;
  localparam logic [N-1:0] PSWD  = 4'b1010;

  // clock / reset and DUT signals
  logic            clk       = 1'b0;
  logic            rst       = 1'b1;
  logic            ent_valid = 1'b0;
  logic [N-1:0]    ent_vn    = '0;
  logic            exit_req  = 1'b0;
  logic [N-1:0]    exit_pswd = '0;
  logic [N-1:0]    exit_vn   = '0;
  logic            ent_ack;
  logic [IW-1:0]   ent_slot;
  logic            full;
  logic [IW:0]     occ_count;
  logic            busy;
  logic            exit_gate;
  logic [IW-1:0]   exit_slot;
  logic            exit_done;
  logic [1:0]      exit_err;
`ifdef PARK_EXIT_FEE_EN
  logic            tick = 1'b0;
  logic [7:0]      fee;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  park_exit_ctrl #(.N(N), .SLOTS(SLOTS), .PASSWORD(PSWD), .GATE_CYCLES(G)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef PARK_EXIT_FEE_EN
    .tick      (tick),
    .fee       (fee),
`endif
    .ent_valid (ent_valid),
    .ent_vn    (ent_vn),
    .ent_ack   (ent_ack),
    .ent_slot  (ent_slot),
    .full      (full),
    .occ_count (occ_count),
    .exit_req  (exit_req),
    .exit_pswd (exit_pswd),
    .exit_vn   (exit_vn),
    .busy      (busy),
    .exit_gate (exit_gate),
    .exit_slot (exit_slot),
    .exit_done (exit_done),
    .exit_err  (exit_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit              m_valid [SLOTS];
  logic [N-1:0]    m_vn    [SLOTS];
  int              m_dur   [SLOTS];
  int              t = 0;
  bit              x_active = 0;
  bit              x_ok = 0;
  int              x_e = 0, x_match = -1, x_end = 0, x_done = 0;
  logic [N-1:0]    x_vn = '0;
  logic [1:0]      x_err = 2'b00;
  bit              e_ack = 0, e_gate = 0, e_done = 0, e_busy = 0;
  int              e_slot = 0, e_xslot = 0, e_fee = 0;
  logic [1:0]      e_err = 2'b00;

  // An accepted request at edge e examines slot k at edge e+2+k against the table
  // as it stood before that edge; a match opens the gate for G cycles from that edge.
  always @(posedge clk) begin : model
    bit sv [SLOTS];
    int cnt;
    int k;
    int fk;
    t++;
    if (rst) begin
      for (int i = 0; i < SLOTS; i++) begin
        m_valid[i] = 0;
        m_dur[i]   = 0;
      end
      x_active = 0;
      e_ack = 0; e_slot = 0; e_gate = 0; e_done = 0; e_busy = 0;
      e_err = 2'b00; e_xslot = 0; e_fee = 0;
    end else begin
      sv  = m_valid;
      cnt = 0;
      for (int i = 0; i < SLOTS; i++) cnt += int'(sv[i]);
      if (x_active && x_ok && x_match < 0 && t >= x_e + 2 && t <= x_e + SLOTS + 1) begin
        k = t - x_e - 2;
        if (sv[k] && m_vn[k] == x_vn) begin
          x_match    = t;
          x_end      = t + G;
          x_done     = t + G - 1;
          x_err      = 2'b00;
          e_xslot    = k;
          e_fee      = m_dur[k];
          m_valid[k] = 0;
        end
      end
`ifdef PARK_EXIT_FEE_EN
      for (int i = 0; i < SLOTS; i++)
        if (tick && sv[i] && m_dur[i] < 255) m_dur[i]++;
`endif
      e_ack = 0;
      if (ent_valid && cnt < SLOTS) begin
        fk = 0;
        for (int i = SLOTS - 1; i >= 0; i--) if (!sv[i]) fk = i;
        m_valid[fk] = 1;
        m_vn[fk]    = ent_vn;
        m_dur[fk]   = 0;
        e_ack       = 1;
        e_slot      = fk;
      end
      if (exit_req && !e_busy) begin
        x_active = 1;
        x_e      = t;
        x_vn     = exit_vn;
        x_ok     = (exit_pswd == PSWD);
        x_match  = -1;
        if (!x_ok) begin
          x_done = t + 2; x_end = t + 2; x_err = 2'b01;
        end else begin
          x_done = t + SLOTS + 2; x_end = t + SLOTS + 2; x_err = 2'b10;
        end
      end
      e_gate = x_active && x_match >= 0 && t >= x_match && t < x_match + G;
      e_done = x_active && t == x_done;
      e_busy = x_active && t < x_end;
      if (e_done) e_err = x_err;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge clk) begin : compare
    int cnt;
    #1;
    cnt = 0;
    for (int i = 0; i < SLOTS; i++) cnt += int'(m_valid[i]);
    chk("ent_ack", ent_ack, e_ack);
    if (e_ack) chk("ent_slot", ent_slot, e_slot);
    chk("occ_count", occ_count, cnt);
    chk("full", full, (cnt == SLOTS));
    chk("exit_gate", exit_gate, e_gate);
    chk("exit_done", exit_done, e_done);
    chk("busy", busy, e_busy);
    if (e_done) chk("exit_err", exit_err, e_err);
    if (e_gate) chk("exit_slot", exit_slot, e_xslot);
`ifdef PARK_EXIT_FEE_EN
    if (e_done && e_err == 2'b00) chk("fee", fee, e_fee);
`endif
  end

  // ---------------- driver tasks ----------------
  task automatic entry(input logic [N-1:0] vn, output logic ack, output int slot);
    ent_valid = 1'b1;
    ent_vn    = vn;
    @(negedge clk);
    ack       = ent_ack;
    slot      = int'(ent_slot);
    ent_valid = 1'b0;
  endtask

  // n counts edges after the one that sampled exit_req.
  task automatic exit_txn(input logic [N-1:0] pswd, input logic [N-1:0] vn,
                          input int ent_at, input logic [N-1:0] side_vn, input int req2_at,
                          output int gate_at, output int gate_cnt, output int done_at,
                          output logic [1:0] err, output int slot,
                          output logic side_ack, output int fee_v);
    exit_req  = 1'b1;
    exit_pswd = pswd;
    exit_vn   = vn;
    @(negedge clk);
    exit_req  = 1'b0;
    gate_at = -1; gate_cnt = 0; done_at = -1; err = 2'b11; slot = -1;
    side_ack = 1'b0; fee_v = -1;
    for (int n = 0; n < 60 && done_at < 0; n++) begin
      if (ent_at >= 0 && n == ent_at + 1) begin
        side_ack  = ent_ack;
        ent_valid = 1'b0;
      end
      if (req2_at >= 0 && n == req2_at + 1) exit_req = 1'b0;
      if (exit_gate) begin
        if (gate_at < 0) begin
          gate_at = n;
          slot    = int'(exit_slot);
        end
        gate_cnt++;
      end
      if (exit_done) begin
        done_at = n;
        err     = exit_err;
`ifdef PARK_EXIT_FEE_EN
        fee_v   = int'(fee);
`endif
      end
      if (ent_at >= 0 && n == ent_at) begin
        ent_valid = 1'b1;
        ent_vn    = side_vn;
      end
      if (req2_at >= 0 && n == req2_at) begin
        exit_req  = 1'b1;
        exit_pswd = PSWD;
        exit_vn   = side_vn;
      end
      if (done_at < 0) @(negedge clk);
    end
    ent_valid = 1'b0;
    exit_req  = 1'b0;
    chk("exit_done_seen", (done_at >= 0), 1);
  endtask

  // ---------------- directed stimulus ----------------
  logic [N-1:0] fill_vn [14];

  initial begin : stim
    logic       ak;
    int         sl, ga, gc, da, xs, fv, dones;
    logic [1:0] er;
    logic       sa;
    fill_vn = '{4'd12, 4'd13, 4'd14, 4'd15, 4'd0, 4'd1, 4'd2,
                4'd4, 4'd6, 4'd7, 4'd8, 4'd10, 4'd11, 4'd9};
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ent_ack", ent_ack, 0);
    chk("rst_ent_slot", ent_slot, 0);
    chk("rst_full", full, 0);
    chk("rst_occ", occ_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gate", exit_gate, 0);
    chk("rst_exit_slot", exit_slot, 0);
    chk("rst_done", exit_done, 0);
    chk("rst_err", exit_err, 0);
    rst = 1'b0;
    @(negedge clk);

    // three registrations
    entry(4'd5, ak, sl); chk("e5_ack", ak, 1); chk("e5_slot", sl, 0);
    entry(4'd9, ak, sl); chk("e9_ack", ak, 1); chk("e9_slot", sl, 1);
    entry(4'd3, ak, sl); chk("e3_ack", ak, 1); chk("e3_slot", sl, 2);
    chk("occ_after_3", occ_count, 3);

    // good exit of vn 9 from slot 1
    exit_txn(PSWD, 4'd9, -1, 4'd0, -1, ga, gc, da, er, xs, sa, fv);
    chk("x9_gate_edge", ga, 3);
    chk("x9_gate_cycles", gc, 4);
    chk("x9_slot", xs, 1);
    chk("x9_done_edge", da, 6);
    chk("x9_err", er, 2'b00);
    @(negedge clk);
    chk("x9_occ", occ_count, 2);
    chk("x9_gate_closed", exit_gate, 0);

    // wrong password
    exit_txn(4'b0110, 4'd5, -1, 4'd0, -1, ga, gc, da, er, xs, sa, fv);
    chk("bad_pw_done_edge", da, 2);
    chk("bad_pw_err", er, 2'b01);
    chk("bad_pw_gate", gc, 0);
    chk("bad_pw_occ", occ_count, 2);

    // absent vehicle; a second request while busy must be ignored
    exit_txn(PSWD, 4'd7, -1, 4'd5, 5, ga, gc, da, er, xs, sa, fv);
    chk("nf_done_edge", da, 18);
    chk("nf_err", er, 2'b10);
    chk("nf_gate", gc, 0);
    dones = 0;
    repeat (25) begin
      @(negedge clk);
      if (exit_done) dones++;
    end
    chk("ignored_req_dones", dones, 0);
    chk("ignored_req_occ", occ_count, 2);

    // fill every slot: free slot 1 first, then 3..15
    for (int i = 0; i < 14; i++) begin
      entry(fill_vn[i], ak, sl);
      chk("fill_ack", ak, 1);
      chk("fill_slot", sl, (i == 0) ? 1 : i + 2);
    end
    chk("fill_full", full, 1);
    chk("fill_occ", occ_count, 16);
    entry(4'd1, ak, sl);
    chk("full_drop_ack", ak, 0);
    chk("full_drop_occ", occ_count, 16);

    // free slot 4 (vn 14) with an entry landing on the same edge
    exit_txn(PSWD, 4'd14, 5, 4'd6, -1, ga, gc, da, er, xs, sa, fv);
    chk("x14_gate_edge", ga, 6);
    chk("x14_slot", xs, 4);
    chk("x14_same_edge_ack", sa, 0);
    chk("x14_done_edge", da, 9);
    chk("x14_occ", occ_count, 15);
    chk("x14_full", full, 0);
    entry(4'd6, ak, sl);
    chk("refill_ack", ak, 1);
    chk("refill_slot", sl, 4);
    chk("refill_full", full, 1);

    // reset while the gate is open
    exit_req = 1'b1; exit_pswd = PSWD; exit_vn = 4'd5;
    @(negedge clk);
    exit_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_gate", exit_gate, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("post_rst_gate", exit_gate, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_occ", occ_count, 0);
    chk("post_rst_full", full, 0);
    @(negedge clk);

`ifdef PARK_EXIT_FEE_EN
    entry(4'd2, ak, sl);
    chk("fee1_slot", sl, 0);
    tick = 1'b1;
    repeat (300) @(negedge clk);
    tick = 1'b0;
    exit_txn(PSWD, 4'd2, -1, 4'd0, -1, ga, gc, da, er, xs, sa, fv);
    chk("fee_saturated", fv, 255);
    chk("fee1_err", er, 2'b00);
    entry(4'd2, ak, sl);
    chk("fee2_slot", sl, 0);
    tick = 1'b1;
    repeat (10) @(negedge clk);
    tick = 1'b0;
    exit_txn(PSWD, 4'd2, -1, 4'd0, -1, ga, gc, da, er, xs, sa, fv);
    chk("fee_ten", fv, 10);
`endif

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running, expected to finish");
    $fatal(1, "watchdog expired");
  end

endmodule
